// File: rtl/pulse_det_pkg.sv
// Shared types and helpers for the pulse width detector.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package pulse_det_pkg;

  // Per-channel classifier states; ARM swallows any pulse already running at reset release.
  typedef enum logic [1:0] {
    ARM   = 2'd0,
    IDLE  = 2'd1,
    PULSE = 2'd2,
    LONG  = 2'd3
  } pd_state_e;

  localparam int STAT_W = 8;

  // Saturating increment used by the statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/pulse_width_channel.sv
// One channel: edge strobes and pulse-width classification, optional stats (PULSE_DET_STATS_EN).
// Latency: strobes are combinational from registered state and the current input (zero cycles).
// Backpressure: none; every event is presented exactly once in its cycle.
module pulse_width_channel
  import pulse_det_pkg::*;
#(
  parameter int   MIN_WIDTH = 1,
  parameter int   MAX_WIDTH = 3,
  parameter int   CNT_W     = 2,
  parameter logic POL       = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_i,
  input  logic              stat_clr_i,
  output logic              rise_o,
  output logic              fall_o,
  output logic              ok_o,
  output logic              short_o,
  output logic              long_o,
  output logic [STAT_W-1:0] ok_cnt_o,
  output logic [STAT_W-1:0] long_cnt_o
);

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_WIDTH);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WIDTH);

  logic             act;
  logic             act_q;
  pd_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cls_ok, cls_short, cls_long;

  assign act = a_i ^ POL;

  // State register: previous level, FSM state and width counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q   <= 1'b0;
      state_q <= ARM;
      cnt_q   <= '0;
    end else begin
      act_q   <= act;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, width counting and classification of the pulse ending this cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cls_ok    = 1'b0;
    cls_short = 1'b0;
    cls_long  = 1'b0;
    case (state_q)
      ARM: begin
        if (!act) state_d = IDLE;
      end
      IDLE: begin
        if (act) begin
          state_d = PULSE;
          cnt_d   = CNT_W'(1);
        end
      end
      PULSE: begin
        if (act) begin
          // Counter saturates at MAX_C; one more active cycle means the pulse is too long.
          if (cnt_q == MAX_C) state_d = LONG;
          else                cnt_d   = cnt_q + CNT_W'(1);
        end else begin
          state_d = IDLE;
          if (cnt_q < MIN_C) cls_short = 1'b1;
          else               cls_ok    = 1'b1;
        end
      end
      LONG: begin
        if (!act) begin
          state_d  = IDLE;
          cls_long = 1'b1;
        end
      end
      default: state_d = ARM;
    endcase
  end

  // Outputs are forced low for as long as reset is held, not just after the next edge.
  assign rise_o  = ~rst & act & ~act_q;
  assign fall_o  = ~rst & ~act & act_q;
  assign ok_o    = ~rst & cls_ok;
  assign short_o = ~rst & cls_short;
  assign long_o  = ~rst & cls_long;

`ifdef PULSE_DET_STATS_EN
  logic [STAT_W-1:0] ok_cnt_q, ok_cnt_d;
  logic [STAT_W-1:0] long_cnt_q, long_cnt_d;

  // Counter next values: a clear request beats a coincident event.
  always_comb begin
    ok_cnt_d   = ok_cnt_q;
    long_cnt_d = long_cnt_q;
    if (stat_clr_i) begin
      ok_cnt_d   = '0;
      long_cnt_d = '0;
    end else begin
      if (cls_ok)   ok_cnt_d   = sat_inc(ok_cnt_q);
      if (cls_long) long_cnt_d = sat_inc(long_cnt_q);
    end
  end

  // Statistics counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok_cnt_q   <= '0;
      long_cnt_q <= '0;
    end else begin
      ok_cnt_q   <= ok_cnt_d;
      long_cnt_q <= long_cnt_d;
    end
  end

  assign ok_cnt_o   = ok_cnt_q;
  assign long_cnt_o = long_cnt_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr_i;
  assign ok_cnt_o        = '0;
  assign long_cnt_o      = '0;
`endif

endmodule

// File: rtl/pulse_width_detector.sv
// Multi-channel edge / pulse-width classifier; stats counters under PULSE_DET_STATS_EN.
// Latency: zero cycles, outputs combinational from registered state and the current input.
// Backpressure: none; channels are independent and never stall.
module pulse_width_detector
  import pulse_det_pkg::*;
#(
  parameter int              N_CH      = 2,
  parameter int              MIN_WIDTH = 1,
  parameter int              MAX_WIDTH = 3,
  parameter logic [N_CH-1:0] POLARITY  = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        a,
  output logic [N_CH-1:0]        rise,
  output logic [N_CH-1:0]        fall,
  output logic [N_CH-1:0]        pulse_ok,
  output logic [N_CH-1:0]        pulse_short,
  output logic [N_CH-1:0]        pulse_long,
  input  logic                   stat_clr,
  output logic [N_CH*STAT_W-1:0] ok_cnt,
  output logic [N_CH*STAT_W-1:0] long_cnt
);

  localparam int CNT_W = $clog2(MAX_WIDTH + 1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pulse_width_channel #(
      .MIN_WIDTH (MIN_WIDTH),
      .MAX_WIDTH (MAX_WIDTH),
      .CNT_W     (CNT_W),
      .POL       (POLARITY[i])
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .a_i        (a[i]),
      .stat_clr_i (stat_clr),
      .rise_o     (rise[i]),
      .fall_o     (fall[i]),
      .ok_o       (pulse_ok[i]),
      .short_o    (pulse_short[i]),
      .long_o     (pulse_long[i]),
      .ok_cnt_o   (ok_cnt[i*STAT_W +: STAT_W]),
      .long_cnt_o (long_cnt[i*STAT_W +: STAT_W])
    );
  end

endmodule
